// File: rtl/neural_simd_pipe_if.sv
// Handshake bundle for neural_simd_pipe: operand beat in, result beat out.
// sat_flags exists only when NEURAL_SIMD_SATFLAG_EN is defined.
interface neural_simd_pipe_if #(
    parameter int LANES = 4,
    parameter int LW    = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            in_mode;
    logic [LANES*LW-1:0]   rs1;
    logic [LANES*LW-1:0]   rs2;
    logic [LANES*LW-1:0]   mask;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*LW-1:0]   rd;
`ifdef NEURAL_SIMD_SATFLAG_EN
    logic [LANES-1:0]      sat_flags;

    modport master (
        output in_valid, in_mode, rs1, rs2, mask, out_ready,
        input  in_ready, out_valid, rd, sat_flags
    );
    modport slave (
        input  in_valid, in_mode, rs1, rs2, mask, out_ready,
        output in_ready, out_valid, rd, sat_flags
    );
`else
    modport master (
        output in_valid, in_mode, rs1, rs2, mask, out_ready,
        input  in_ready, out_valid, rd
    );
    modport slave (
        input  in_valid, in_mode, rs1, rs2, mask, out_ready,
        output in_ready, out_valid, rd
    );
`endif
endinterface

// File: rtl/neural_simd_pipe.sv
// Two-stage per-lane blend / sat add / sat sub / max unit with valid/ready.
// Optional per-lane clamp flags via NEURAL_SIMD_SATFLAG_EN.
module neural_simd_pipe #(
    parameter int LANES = 4,
    parameter int LW    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    neural_simd_pipe_if.slave bus
);
    localparam int PW = 2 * LW + 1;
    localparam logic [PW-1:0] M_P    = PW'((1 << LW) - 1);
    localparam logic [PW-1:0] HALF_P = M_P >> 1;
    localparam logic [LW-1:0] M_L    = '1;

    logic [LANES-1:0][LW-1:0] a_l;
    logic [LANES-1:0][LW-1:0] b_l;
    logic [LANES-1:0][LW-1:0] m_l;

    assign a_l = bus.rs1;
    assign b_l = bus.rs2;
    assign m_l = bus.mask;

    logic                     s1_valid_q, s1_valid_d;
    logic [1:0]               s1_mode_q, s1_mode_d;
    logic [LANES-1:0][PW-1:0] s1_p_q, s1_p_d;
    logic                     s2_valid_q, s2_valid_d;
    logic [LANES-1:0][LW-1:0] s2_rd_q, s2_rd_d;

    logic                     s1_adv, s2_adv, in_fire, s2_ld;
    logic [LANES-1:0][PW-1:0] lane_p;
    logic [LANES-1:0][LW-1:0] lane_r;

    // S1: raw product sum, carry-out sum, or borrow-tagged difference
    always_comb begin
        lane_p = '0;
        for (int i = 0; i < LANES; i++) begin
            unique case (bus.in_mode)
                2'd0: lane_p[i] = PW'(a_l[i]) * PW'(m_l[i])
                                + PW'(b_l[i]) * (M_P - PW'(m_l[i]));
                2'd1: lane_p[i] = PW'(a_l[i]) + PW'(b_l[i]);
                2'd2: lane_p[i] = PW'({1'b0, a_l[i]} - {1'b0, b_l[i]});
                2'd3: lane_p[i] = (a_l[i] >= b_l[i]) ? PW'(a_l[i])
                                                     : PW'(b_l[i]);
            endcase
        end
    end

    // S2: bit LW of the S1 value is the overflow / borrow indicator
    always_comb begin
        lane_r = '0;
        for (int i = 0; i < LANES; i++) begin
            unique case (s1_mode_q)
                2'd0: lane_r[i] = LW'((s1_p_q[i] + HALF_P) / M_P);
                2'd1: lane_r[i] = s1_p_q[i][LW] ? M_L : s1_p_q[i][LW-1:0];
                2'd2: lane_r[i] = s1_p_q[i][LW] ? '0 : s1_p_q[i][LW-1:0];
                2'd3: lane_r[i] = s1_p_q[i][LW-1:0];
            endcase
        end
    end

    always_comb begin
        s2_adv     = !s2_valid_q || bus.out_ready;
        s1_adv     = !s1_valid_q || s2_adv;
        in_fire    = bus.in_valid && s1_adv;
        s2_ld      = s2_adv && s1_valid_q;
        s1_valid_d = s1_adv ? bus.in_valid : s1_valid_q;
        s1_mode_d  = in_fire ? bus.in_mode : s1_mode_q;
        s1_p_d     = in_fire ? lane_p : s1_p_q;
        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
        s2_rd_d    = s2_ld ? lane_r : s2_rd_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= '0;
            s1_p_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_rd_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_mode_q  <= s1_mode_d;
            s1_p_q     <= s1_p_d;
            s2_valid_q <= s2_valid_d;
            s2_rd_q    <= s2_rd_d;
        end
    end

`ifdef NEURAL_SIMD_SATFLAG_EN
    logic [LANES-1:0] lane_f;
    logic [LANES-1:0] s2_flag_q, s2_flag_d;

    always_comb begin
        lane_f = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_f[i] = (s1_mode_q == 2'd1 || s1_mode_q == 2'd2)
                        && s1_p_q[i][LW];
        end
        s2_flag_d = s2_ld ? lane_f : s2_flag_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_flag_q <= '0;
        end else begin
            s2_flag_q <= s2_flag_d;
        end
    end

    assign bus.sat_flags = s2_flag_q;
`endif

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_valid_q;
    assign bus.rd        = s2_rd_q;
endmodule

// File: tb/tb_neural_simd_pipe.sv
// Self-checking bench for neural_simd_pipe: directed steps plus a
// randomized stream scored against a per-lane arithmetic model.
module tb_neural_simd_pipe;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    neural_simd_pipe_if #(.LANES(4), .LW(8))  b0 ();
    neural_simd_pipe_if #(.LANES(1), .LW(4))  b1 ();
    neural_simd_pipe_if #(.LANES(8), .LW(16)) b2 ();

    neural_simd_pipe #(.LANES(4), .LW(8)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(b0)
    );
    neural_simd_pipe #(.LANES(1), .LW(4)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1)
    );
    neural_simd_pipe #(.LANES(8), .LW(16)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(b2)
    );

    typedef struct {
        logic [31:0] rd;
        logic [3:0]  f;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          cons_q[$];
    int          acc_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc_no = 0;
    int          last_cons = -10;
    bit          acc_last = 0;
    bit          stall_prev = 0;
    logic [31:0] rd_prev;
    logic [3:0]  f_prev;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Lane-by-lane arithmetic straight from the operation definitions
    function automatic logic [127:0] ref_vec(
        input int lanes, input int lw, input logic [1:0] mode,
        input logic [127:0] a, input logic [127:0] b,
        input logic [127:0] m, output logic [15:0] flg);
        longint mx;
        logic [127:0] res;
        mx  = (longint'(1) << lw) - 1;
        res = '0;
        flg = '0;
        for (int i = 0; i < lanes; i++) begin
            logic [127:0] ta, tb2, tm;
            longint x, y, w, r;
            ta  = a >> (i * lw);
            tb2 = b >> (i * lw);
            tm  = m >> (i * lw);
            x = longint'(ta[15:0]) & mx;
            y = longint'(tb2[15:0]) & mx;
            w = longint'(tm[15:0]) & mx;
            case (mode)
                2'd0: r = (x * w + y * (mx - w) + mx / 2) / mx;
                2'd1: begin
                    r = x + y;
                    if (r > mx) begin
                        r = mx;
                        flg[i] = 1'b1;
                    end
                end
                2'd2: begin
                    if (x < y) begin
                        r = 0;
                        flg[i] = 1'b1;
                    end else begin
                        r = x - y;
                    end
                end
                default: r = (x >= y) ? x : y;
            endcase
            res = res | (128'(r) << (i * lw));
        end
        return res;
    endfunction

    function automatic logic [31:0] rnd_vec();
        logic [31:0] v;
        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(3))
                0:       v[i*8 +: 8] = 8'h00;
                1:       v[i*8 +: 8] = 8'hFF;
                default: v[i*8 +: 8] = 8'($urandom_range(255));
            endcase
        end
        return v;
    endfunction

    task automatic drive(input bit v, input logic [1:0] mode,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] m);
        b0.in_valid = v;
        b0.in_mode  = mode;
        b0.rs1      = a;
        b0.rs2      = b;
        b0.mask     = m;
    endtask

    // One clock of the queue model for the 4x8 instance
    task automatic cyc();
        logic [15:0]  f;
        logic [127:0] e;
        bit           ev;
        exp_t         x;
        @(negedge clk);
        cyc_no++;
        acc_last = 0;
        ev = sb.size() > 0;
        if (ev) ev = cyc_no >= sb[0].acc + 2 && cyc_no >= last_cons + 1;
        check("out_valid", 128'(b0.out_valid), 128'(ev));
        check("in_ready", 128'(b0.in_ready),
              128'(sb.size() < 2 || b0.out_ready));
        if (stall_prev) begin
            check("stall_rd_hold", 128'(b0.rd), 128'(rd_prev));
`ifdef NEURAL_SIMD_SATFLAG_EN
            check("stall_flag_hold", 128'(b0.sat_flags), 128'(f_prev));
`endif
        end
        if (b0.out_valid && b0.out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_beat", 128'(b0.out_valid), 128'(0));
            end else begin
                x = sb.pop_front();
                check("rd", 128'(b0.rd), 128'(x.rd));
`ifdef NEURAL_SIMD_SATFLAG_EN
                check("sat_flags", 128'(b0.sat_flags), 128'(x.f));
`endif
                cons_q.push_back(cyc_no);
                last_cons = cyc_no;
            end
        end
        if (b0.in_valid && b0.in_ready) begin
            e = ref_vec(4, 8, b0.in_mode, 128'(b0.rs1), 128'(b0.rs2),
                        128'(b0.mask), f);
            x.rd  = e[31:0];
            x.f   = f[3:0];
            x.acc = cyc_no;
            sb.push_back(x);
            acc_q.push_back(cyc_no);
            acc_last = 1;
        end
        stall_prev = b0.out_valid && !b0.out_ready;
        rd_prev = b0.rd;
`ifdef NEURAL_SIMD_SATFLAG_EN
        f_prev = b0.sat_flags;
`else
        f_prev = '0;
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0]  va[5], vb[5], vm[5];
        logic [1:0]   vmode[5];
        logic [127:0] w_a, w_b, w_m, e;
        logic [15:0]  f;
        int           k;

        rst_n = 1'b0;
        drive(0, 2'd0, '0, '0, '0);
        b0.out_ready = 1'b1;
        b1.in_valid = 1'b0; b1.in_mode = '0; b1.out_ready = 1'b1;
        b1.rs1 = '0; b1.rs2 = '0; b1.mask = '0;
        b2.in_valid = 1'b0; b2.in_mode = '0; b2.out_ready = 1'b1;
        b2.rs1 = '0; b2.rs2 = '0; b2.mask = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 128'(b0.out_valid), 128'(0));
        check("rst_rd", 128'(b0.rd), 128'(0));
        check("rst_in_ready", 128'(b0.in_ready), 128'(1));
`ifdef NEURAL_SIMD_SATFLAG_EN
        check("rst_sat_flags", 128'(b0.sat_flags), 128'(0));
`endif
        rst_n = 1'b1;

        // Blend directed vector and latency
        drive(1, 2'd0, 32'h64646464, 32'hC8C8C8C8, 32'h808000FF);
        cyc();
        drive(0, 2'd0, '0, '0, '0);
        check("blend_lat_edge1", 128'(b0.out_valid), 128'(0));
        cyc();
        check("blend_lat_edge2", 128'(b0.out_valid), 128'(1));
        check("blend_rd", 128'(b0.rd), 128'(32'h9696C864));
        cyc();

        drive(1, 2'd1, 32'hF0107F01, 32'h20107F01, '0);
        cyc();
        drive(0, 2'd0, '0, '0, '0);
        cyc();
        check("satadd_rd", 128'(b0.rd), 128'(32'hFF20FE02));
`ifdef NEURAL_SIMD_SATFLAG_EN
        check("satadd_flags", 128'(b0.sat_flags), 128'(4'b1000));
`endif
        cyc();

        drive(1, 2'd2, 32'h10FF0000, 32'h2001FF00, '0);
        cyc();
        drive(0, 2'd0, '0, '0, '0);
        cyc();
        check("satsub_rd", 128'(b0.rd), 128'(32'h00FE0000));
`ifdef NEURAL_SIMD_SATFLAG_EN
        check("satsub_flags", 128'(b0.sat_flags), 128'(4'b1010));
`endif
        cyc();

        // Back-to-back mode switching 3,0,1,2
        cons_q.delete();
        acc_q.delete();
        drive(1, 2'd3, rnd_vec(), rnd_vec(), rnd_vec()); cyc();
        drive(1, 2'd0, rnd_vec(), rnd_vec(), rnd_vec()); cyc();
        drive(1, 2'd1, rnd_vec(), rnd_vec(), rnd_vec()); cyc();
        drive(1, 2'd2, rnd_vec(), rnd_vec(), rnd_vec()); cyc();
        drive(0, 2'd0, '0, '0, '0);
        repeat (4) cyc();
        check("mix_count", 128'(cons_q.size()), 128'(4));
        if (cons_q.size() == 4 && acc_q.size() == 4) begin
            check("mix_no_bubble", 128'(cons_q[3] - cons_q[0]), 128'(3));
            check("mix_latency", 128'(cons_q[0] - acc_q[0]), 128'(2));
        end

        // Backpressure: 5 beats offered against a stalled sink
        for (int i = 0; i < 5; i++) begin
            va[i] = rnd_vec(); vb[i] = rnd_vec(); vm[i] = rnd_vec();
            vmode[i] = 2'($urandom_range(3));
        end
        b0.out_ready = 1'b0;
        k = 0;
        drive(1, vmode[0], va[0], vb[0], vm[0]);
        repeat (5) begin
            cyc();
            if (acc_last) begin
                k++;
                if (k < 5) drive(1, vmode[k], va[k], vb[k], vm[k]);
                else drive(0, 2'd0, '0, '0, '0);
            end
        end
        check("bp_accepted", 128'(k), 128'(2));
        check("bp_in_ready", 128'(b0.in_ready), 128'(0));
        b0.out_ready = 1'b1;
        for (int t = 0; t < 20 && (k < 5 || sb.size() > 0); t++) begin
            cyc();
            if (acc_last) begin
                k++;
                if (k < 5) drive(1, vmode[k], va[k], vb[k], vm[k]);
                else drive(0, 2'd0, '0, '0, '0);
            end
        end
        check("bp_all_accepted", 128'(k), 128'(5));
        check("bp_drained", 128'(sb.size()), 128'(0));

        // Reset with two beats in flight
        b0.out_ready = 1'b0;
        drive(1, 2'd1, rnd_vec(), rnd_vec(), '0);
        k = 0;
        for (int t = 0; t < 6 && k < 2; t++) begin
            cyc();
            if (acc_last) k++;
        end
        check("rst_mid_inflight", 128'(sb.size()), 128'(2));
        drive(0, 2'd0, '0, '0, '0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_out_valid", 128'(b0.out_valid), 128'(0));
        check("rst_mid_rd", 128'(b0.rd), 128'(0));
        check("rst_mid_in_ready", 128'(b0.in_ready), 128'(1));
`ifdef NEURAL_SIMD_SATFLAG_EN
        check("rst_mid_flags", 128'(b0.sat_flags), 128'(0));
`endif
        sb.delete();
        stall_prev = 0;
        last_cons = -10;
        rst_n = 1'b1;
        b0.out_ready = 1'b1;
        repeat (6) cyc();

        // Random stream with random backpressure; held while stalled
        for (int t = 0; t < 400; t++) begin
            if (!b0.in_valid || acc_last) begin
                if ($urandom_range(3) != 0)
                    drive(1, 2'($urandom_range(3)),
                          rnd_vec(), rnd_vec(), rnd_vec());
                else
                    drive(0, 2'd0, '0, '0, '0);
            end
            b0.out_ready = ($urandom_range(3) != 0);
            cyc();
        end
        drive(0, 2'd0, '0, '0, '0);
        b0.out_ready = 1'b1;
        for (int t = 0; t < 10 && sb.size() > 0; t++) cyc();
        check("rand_drained", 128'(sb.size()), 128'(0));

        // LANES=1, LW=4 blend
        check("p1_in_ready", 128'(b1.in_ready), 128'(1));
        b1.in_valid = 1'b1; b1.in_mode = 2'd0;
        b1.rs1 = 4'hF; b1.rs2 = 4'h0; b1.mask = 4'h8;
        @(posedge clk); #1;
        b1.in_valid = 1'b0;
        @(posedge clk); #1;
        check("p1_out_valid", 128'(b1.out_valid), 128'(1));
        check("p1_rd", 128'(b1.rd), 128'(4'h8));
        e = ref_vec(1, 4, 2'd0, 128'(4'hF), 128'(4'h0), 128'(4'h8), f);
        check("p1_rd_model", 128'(b1.rd), e);

        // LANES=8, LW=16: full mask, then a random blend
        w_a = {$urandom, $urandom, $urandom, $urandom};
        w_b = {$urandom, $urandom, $urandom, $urandom};
        w_m = {$urandom, $urandom, $urandom, $urandom};
        check("p2_in_ready", 128'(b2.in_ready), 128'(1));
        b2.in_valid = 1'b1; b2.in_mode = 2'd0;
        b2.rs1 = w_a; b2.rs2 = w_b; b2.mask = '1;
        @(posedge clk); #1;
        b2.mask = w_m;
        @(posedge clk); #1;
        b2.in_valid = 1'b0;
        check("p2_full_mask_valid", 128'(b2.out_valid), 128'(1));
        check("p2_full_mask", b2.rd, w_a);
        @(posedge clk); #1;
        e = ref_vec(8, 16, 2'd0, w_a, w_b, w_m, f);
        check("p2_blend_valid", 128'(b2.out_valid), 128'(1));
        check("p2_blend", b2.rd, e);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
